// File: rtl/water_supply_pkg.sv
// Shared encodings for the water supply pump controller: FSM states,
// fault codes and the debounced tank level.
package water_supply_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FILL  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_CONFLICT = 2'd1,
        FC_TIMEOUT  = 2'd2
    } fault_code_t;

    localparam logic [1:0] LEVEL_NONE = 2'd0;
    localparam logic [1:0] LEVEL_LOW  = 2'd1;
    localparam logic [1:0] LEVEL_MID  = 2'd2;
    localparam logic [1:0] LEVEL_FULL = 2'd3;

    // Number of wetted sensors; only meaningful when the sensors are consistent.
    function automatic logic [1:0] level_sum(input logic low, input logic mid, input logic high);
        return {1'b0, low} + {1'b0, mid} + {1'b0, high};
    endfunction

endpackage

// File: rtl/level_debouncer.sv
// Single-sensor debouncer: the stable output follows the raw input only after
// the raw value has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module level_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (raw == stable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            stable <= raw;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/water_sensors_checker.sv
// Flags physically impossible sensor combinations: a higher sensor wet while
// the one below it is dry.
module water_sensors_checker (
    input  logic low,
    input  logic mid,
    input  logic high,
    output logic conflict
);
    assign conflict = (mid & ~low) | (high & ~mid);
endmodule

// File: rtl/water_supply_controller.sv
// Supply pump controller: debounced level sensing, conflict detection and a
// four-state pump FSM with hysteresis, minimum toggle time and fill timeout.
module water_supply_controller
    import water_supply_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int MIN_TOGGLE_CYCLES = 8,
    parameter int FAULT_CYCLES      = 3,
    parameter int FILL_TIMEOUT      = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       low_level,
    input  logic       mid_level,
    input  logic       high_level,
    input  logic       enable,
    input  logic       fault_ack,
    output logic       pump_on,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [1:0] level,
    output logic [1:0] state
);
    localparam int TW = $clog2(MIN_TOGGLE_CYCLES + 1);
    localparam int FW = $clog2(FAULT_CYCLES + 1);
    localparam int LW = $clog2(FILL_TIMEOUT + 1);
    localparam logic [TW-1:0] TOG_MAX   = TW'(MIN_TOGGLE_CYCLES);
    localparam logic [FW-1:0] CONF_MAX  = FW'(FAULT_CYCLES);
    localparam logic [FW-1:0] CONF_LAST = FW'(FAULT_CYCLES - 1);
    localparam logic [LW-1:0] FILL_MAX  = LW'(FILL_TIMEOUT);
    localparam logic [LW-1:0] FILL_LAST = LW'(FILL_TIMEOUT - 1);

    logic          low_db, mid_db, high_db, conflict;
    logic [1:0]    last_valid_q, level_now;
    logic          level_up, conf_hit, fill_hit, tog_sat;
    logic [FW-1:0] conf_cnt;
    logic [TW-1:0] tog_cnt;
    logic [LW-1:0] fill_cnt;
    state_t        state_q, state_next;
    fault_code_t   code_q, code_next;
    logic          pump_d, fault_d;

    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_low
        (.clk(clk), .rst_n(rst_n), .raw(low_level), .stable(low_db));
    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mid
        (.clk(clk), .rst_n(rst_n), .raw(mid_level), .stable(mid_db));
    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_high
        (.clk(clk), .rst_n(rst_n), .raw(high_level), .stable(high_db));

    water_sensors_checker u_checker
        (.low(low_db), .mid(mid_db), .high(high_db), .conflict(conflict));

    // During a conflict the last consistent reading is reported unchanged.
    assign level_now = conflict ? last_valid_q : level_sum(low_db, mid_db, high_db);
    assign level_up  = level_now > last_valid_q;
    assign conf_hit  = conflict && (conf_cnt >= CONF_LAST);
    assign fill_hit  = (state_q == ST_FILL) && !level_up && (fill_cnt >= FILL_LAST);
    assign tog_sat   = tog_cnt == TOG_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_valid_q <= LEVEL_NONE;
            conf_cnt     <= '0;
            tog_cnt      <= TOG_MAX;
            fill_cnt     <= '0;
        end else begin
            last_valid_q <= level_now;
            if (!conflict)
                conf_cnt <= '0;
            else if (conf_cnt != CONF_MAX)
                conf_cnt <= conf_cnt + 1'b1;
            if (pump_d != pump_on)
                tog_cnt <= '0;
            else if (!tog_sat)
                tog_cnt <= tog_cnt + 1'b1;
            if (state_q != ST_FILL || level_up)
                fill_cnt <= '0;
            else if (fill_cnt != FILL_MAX)
                fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= FC_NONE;
            pump_on <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_q <= state_next;
            code_q  <= code_next;
            pump_on <= pump_d;
            fault   <= fault_d;
        end
    end

    // Dropping enable leaves FILL at once; minimum on-time yields to safety.
    always_comb begin
        state_next = state_q;
        code_next  = code_q;
        if (state_q != ST_FAULT && conf_hit) begin
            state_next = ST_FAULT;
            code_next  = FC_CONFLICT;
        end else if (fill_hit) begin
            state_next = ST_FAULT;
            code_next  = FC_TIMEOUT;
        end else begin
            case (state_q)
                ST_IDLE: if (enable) state_next = ST_HOLD;
                ST_HOLD: begin
                    if (!enable)
                        state_next = ST_IDLE;
                    else if (level_now <= LEVEL_LOW && tog_sat && !conflict)
                        state_next = ST_FILL;
                end
                ST_FILL: begin
                    if (!enable)
                        state_next = ST_IDLE;
                    else if (level_now == LEVEL_FULL && tog_sat)
                        state_next = ST_HOLD;
                end
                ST_FAULT: begin
                    if (fault_ack && !conflict) begin
                        state_next = ST_IDLE;
                        code_next  = FC_NONE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pump_d  = state_next == ST_FILL;
        fault_d = state_next == ST_FAULT;
    end

    assign fault_code = code_q;
    assign state      = state_q;
    assign level      = level_now;

endmodule

// File: tb/tb_water_supply_controller.sv
// Bench for water_supply_controller: directed vector table, a reset-in-FILL
// sequence and a randomized run checked against a behavioural model.
module tb_water_supply_controller;
    localparam int DEB  = 4;
    localparam int MTOG = 8;
    localparam int FCYC = 3;
    localparam int FTO  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       low_level = 1'b0, mid_level = 1'b0, high_level = 1'b0;
    logic       enable = 1'b0, fault_ack = 1'b0;
    logic       pump_on, fault;
    logic [1:0] fault_code, level, state;

    int n_cmp = 0;
    int n_err = 0;

    water_supply_controller #(
        .DEBOUNCE_CYCLES(DEB), .MIN_TOGGLE_CYCLES(MTOG),
        .FAULT_CYCLES(FCYC), .FILL_TIMEOUT(FTO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .low_level(low_level), .mid_level(mid_level),
        .high_level(high_level), .enable(enable), .fault_ack(fault_ack),
        .pump_on(pump_on), .fault(fault), .fault_code(fault_code),
        .level(level), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural model: unbounded run lengths instead of saturating counters.
    int m_db[3], m_run[3];
    int m_last, m_state, m_code, m_since, m_conf, m_fill;

    function automatic bit m_conflict();
        return (m_db[1] == 1 && m_db[0] == 0) || (m_db[2] == 1 && m_db[1] == 0);
    endfunction

    function automatic int m_level();
        return m_conflict() ? m_last : m_db[0] + m_db[1] + m_db[2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_db[i]  = 0;
            m_run[i] = 0;
        end
        m_last = 0; m_state = 0; m_code = 0;
        m_since = MTOG; m_conf = 0; m_fill = 0;
    endtask

    task automatic model_step();
        int  lv, ns, nc;
        bit  c, up, hit_c, hit_t, tog_ok;
        int  raw[3];
        lv     = m_level();
        c      = m_conflict();
        up     = lv > m_last;
        hit_c  = c && (m_conf + 1 >= FCYC);
        hit_t  = (m_state == 2) && !up && (m_fill + 1 >= FTO);
        tog_ok = m_since >= MTOG;
        ns = m_state;
        nc = m_code;
        if (m_state != 3 && hit_c) begin ns = 3; nc = 1; end
        else if (hit_t) begin ns = 3; nc = 2; end
        else if (m_state != 3 && !enable) ns = 0;
        else if (m_state == 0) ns = 1;
        else if (m_state == 1 && lv <= 1 && tog_ok && !c) ns = 2;
        else if (m_state == 2 && lv == 3 && tog_ok) ns = 1;
        else if (m_state == 3 && fault_ack && !c) begin ns = 0; nc = 0; end
        m_conf = c ? m_conf + 1 : 0;
        m_fill = (m_state == 2 && !up) ? m_fill + 1 : 0;
        m_since = ((ns == 2) != (m_state == 2)) ? 0 : m_since + 1;
        m_last = lv;
        raw[0] = int'(low_level); raw[1] = int'(mid_level); raw[2] = int'(high_level);
        for (int i = 0; i < 3; i++) begin
            if (raw[i] == m_db[i]) m_run[i] = 0;
            else if (m_run[i] + 1 >= DEB) begin m_db[i] = raw[i]; m_run[i] = 0; end
            else m_run[i] = m_run[i] + 1;
        end
        m_state = ns;
        m_code  = nc;
    endtask

    function automatic logic [7:0] dut_vec();
        return {state, pump_on, fault, fault_code, level};
    endfunction

    task automatic compare(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got st=%0d pump=%0b flt=%0b code=%0d lvl=%0d, expected st=%0d pump=%0b flt=%0b code=%0d lvl=%0d",
                     name, got[7:6], got[5], got[4], got[3:2], got[1:0],
                     exp[7:6], exp[5], exp[4], exp[3:2], exp[1:0]);
        end
    endtask

    task automatic tick();
        logic [7:0] exp;
        @(posedge clk);
        model_step();
        #1;
        exp = {2'(m_state), m_state == 2, m_state == 3, 2'(m_code), 2'(m_level())};
        compare("model", dut_vec(), exp);
    endtask

    typedef struct {
        logic       low, mid, high, en, ack;
        int         cycles;
        logic [1:0] st;
        logic       pump, flt;
        logic [1:0] code, lvl;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic l, input logic m, input logic h, input logic e, input logic a,
                       input int n, input logic [1:0] st, input logic p, input logic f,
                       input logic [1:0] code, input logic [1:0] lvl);
        vec_t v;
        v.low = l; v.mid = m; v.high = h; v.en = e; v.ack = a; v.cycles = n;
        v.st = st; v.pump = p; v.flt = f; v.code = code; v.lvl = lvl;
        vecs.push_back(v);
    endtask

    initial begin
        #1ms;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int hold[3];
        //   l m h e a  cyc  st p f code lvl
        add(0,0,0,1,0,  1,   1,0,0,0,0);  // IDLE -> HOLD
        add(0,0,0,1,0,  1,   2,1,0,0,0);  // HOLD -> FILL, first fill not delayed
        add(1,0,0,1,0, 10,   2,1,0,0,1);
        add(1,1,0,1,0, 10,   2,1,0,0,2);
        add(1,1,1,1,0,  4,   2,1,0,0,3);  // level full after debounce
        add(1,1,1,1,0,  1,   1,0,0,0,3);  // 5th edge: pump off
        add(1,0,0,1,0,  4,   1,0,0,0,1);
        add(1,0,0,1,0,  4,   1,0,0,0,1);  // min off-time blocks FILL
        add(1,0,0,1,0,  1,   2,1,0,0,1);
        add(1,1,1,1,0,  4,   2,1,0,0,3);
        add(1,1,1,1,0,  1,   2,1,0,0,3);  // min on-time blocks HOLD
        add(1,1,1,1,0,  4,   1,0,0,0,3);
        add(1,1,0,1,0,  3,   1,0,0,0,3);  // 3-cycle glitch filtered
        add(1,1,1,1,0,  2,   1,0,0,0,3);
        add(1,0,1,1,0,  4,   1,0,0,0,3);  // conflict, level held
        add(1,0,1,1,0,  2,   1,0,0,0,3);
        add(1,0,1,1,0,  1,   3,0,1,1,3);  // conflict fault
        add(1,0,1,1,1,  2,   3,0,1,1,3);  // ack ignored during conflict
        add(1,1,1,1,0,  4,   3,0,1,1,3);
        add(1,1,1,1,1,  1,   0,0,0,0,3);  // ack clears fault
        add(1,1,1,1,0,  1,   1,0,0,0,3);
        add(0,0,0,1,0,  4,   1,0,0,0,0);
        add(0,0,0,1,0,  1,   2,1,0,0,0);
        add(0,0,0,1,0, 63,   2,1,0,0,0);
        add(0,0,0,1,0,  1,   3,0,1,2,0);  // fill timeout
        add(0,0,0,1,1,  1,   0,0,0,0,0);
        add(0,0,0,1,0,  1,   1,0,0,0,0);
        add(0,0,0,1,0,  6,   1,0,0,0,0);
        add(0,0,0,1,0,  1,   2,1,0,0,0);
        add(0,0,0,1,0,  1,   2,1,0,0,0);
        add(0,0,0,0,0,  1,   0,0,0,0,0);  // enable drop overrides min on-time
        add(0,0,0,1,0,  1,   1,0,0,0,0);
        add(0,0,0,1,0,  7,   1,0,0,0,0);
        add(0,0,0,1,0,  1,   2,1,0,0,0);

        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare("reset_outputs", dut_vec(), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            low_level = vecs[i].low; mid_level = vecs[i].mid; high_level = vecs[i].high;
            enable = vecs[i].en; fault_ack = vecs[i].ack;
            repeat (vecs[i].cycles) tick();
            compare($sformatf("vec%0d", i), dut_vec(),
                    {vecs[i].st, vecs[i].pump, vecs[i].flt, vecs[i].code, vecs[i].lvl});
        end

        // Asynchronous reset while filling.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compare("async_reset_in_fill", dut_vec(), 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run with periodic frozen-dry windows to reach timeouts.
        for (int i = 0; i < 3; i++) hold[i] = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if ((cyc % 600) < 130) begin
                low_level = 1'b0; mid_level = 1'b0; high_level = 1'b0;
                enable = 1'b1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (hold[i] == 0) begin
                        hold[i] = $urandom_range(1, 14);
                        case (i)
                            0: low_level  = 1'($urandom_range(0, 1));
                            1: mid_level  = 1'($urandom_range(0, 1));
                            default: high_level = 1'($urandom_range(0, 1));
                        endcase
                    end else begin
                        hold[i] = hold[i] - 1;
                    end
                end
                enable = ($urandom_range(0, 39) != 0);
            end
            fault_ack = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/water_supply_controller.md
# water_supply_controller

Sequential pump controller for the water supply tank. It debounces the low/mid/high level sensors and detects sensor conflicts on the debounced levels. A four-state FSM drives the supply pump with hysteresis, minimum on/off times and fill-timeout protection. It sits between the raw tank sensors and the pump driver, and reports a latched fault to the operator panel.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a raw sensor must differ from its debounced value before the debounced value changes.
- MIN_TOGGLE_CYCLES, 8: minimum cycles between pump_on transitions (anti short-cycling).
- FAULT_CYCLES, 3: consecutive cycles a conflict must persist before FAULT is entered.
- FILL_TIMEOUT, 64: cycles in FILL without a debounced level increase before FAULT is entered.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- low_level  in  1  raw low sensor, 1 = water present.
- mid_level  in  1  raw mid sensor.
- high_level  in  1  raw high sensor.
- enable  in  1  operator enable for automatic filling.
- fault_ack  in  1  operator fault acknowledge, level-sampled.
- pump_on  out  1  pump drive; 1 only in FILL.
- fault  out  1  1 only in FAULT.
- fault_code  out  2  00 none, 01 sensor conflict, 10 fill timeout; held while in FAULT.
- level  out  2  debounced tank level: 0 none, 1 low, 2 low+mid, 3 all.
- state  out  2  FSM state: 0 IDLE, 1 HOLD, 2 FILL, 3 FAULT.

## Operation

- Debounce: per sensor, a counter increments while raw != debounced and clears otherwise; at DEBOUNCE_CYCLES the debounced bit takes the raw value and the counter clears.
- Conflict term on debounced bits: (mid & !low) | (high & !mid). While it is active, level holds its last valid value. Otherwise level = low + mid + high.
- Conflict counter: increments while conflict is active, clears when it is inactive, saturates at FAULT_CYCLES.
- Toggle timer: clears on every pump_on change and saturates at MIN_TOGGLE_CYCLES.
- Fill timer: runs only in FILL; clears on entering FILL and on any debounced level increase.
- Transitions (priority top-down):
  - Any state except FAULT: conflict counter reaches FAULT_CYCLES -> FAULT, code 01.
  - FILL: fill timer reaches FILL_TIMEOUT -> FAULT, code 10.
  - IDLE, HOLD or FILL: enable = 0 -> IDLE. This exit from FILL ignores the toggle timer, because safety overrides minimum on-time.
  - IDLE: enable = 1 -> HOLD.
  - HOLD: level <= 1, toggle timer saturated and no conflict -> FILL.
  - FILL: level = 3 and toggle timer saturated -> HOLD.
  - FAULT: fault_ack = 1 and conflict inactive -> IDLE, fault_code <- 00.
- Simultaneous conflict and timeout: code 01 wins.

## Timing

- Reset values: state IDLE, every output 0, debounced bits 0, debounce/conflict/fill counters 0.
- The toggle timer resets to its saturated value, so the first fill is not delayed.
- Outputs are registered decodes of the state, level and fault registers, with no combinational path from inputs.
- Raw sensor edge -> level change: DEBOUNCE_CYCLES cycles. Level -> state change: the following edge.
- enable edge -> state change: the next edge.
- Reset mid-operation: pump_on falls asynchronously on rst_n low.

## Structure

- Shared package `water_supply_pkg`: state encodings (IDLE/HOLD/FILL/FAULT), fault_code constants, level encoding.
- Sub-module `level_debouncer`: one sensor, parameter DEBOUNCE_CYCLES, ports clk, rst_n, raw, stable. Instantiate three times.
- Conflict term comes from the team's existing water_sensors_checker, fed with the debounced bits.
- Counter widths: $clog2(param + 1).

## Test plan

Defaults for all scenarios: DEBOUNCE_CYCLES 4, MIN_TOGGLE_CYCLES 8, FAULT_CYCLES 3, FILL_TIMEOUT 64.

- Reset then enable = 1, sensors 000 -> state 1 after 1 edge, state 2 and pump_on = 1 after 2 edges; all outputs 0 during reset.
- In FILL, raise low, mid, high 10 cycles apart -> level steps 1, 2, 3. pump_on falls at the 5th edge after high rises; state 1.
- In HOLD at level 3, pulse high = 0 for 3 cycles -> level stays 3, no FILL entry. Drop mid and high for 5+ cycles -> FILL, but not before 8 cycles since the last pump_on fall.
- Set high = 1, mid = 0 -> fault = 1, code 01, pump_on = 0 after 4 + 3 cycles. fault_ack while the conflict persists -> stays FAULT. Clear the conflict, then ack -> IDLE, code 00.
- FILL with sensors frozen at 000 -> FAULT, code 10 at fill timer = 64.
- Drop enable 2 cycles into FILL -> pump_on = 0 next edge, state 0. Assert rst_n = 0 mid-FILL -> pump_on = 0 immediately.
